apb3_fifo_slave: RTL



---
 rtl/apb3_fifo_slave_if.sv | 21 ++
 rtl/apb3_fifo_slave.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/apb3_fifo_slave_if.sv
// APB3 bus bundle between the interconnect (master) and the mailbox FIFO completer (slave).
interface apb3_fifo_slave_if;
   logic        PSEL;
   logic [4:0]  PADDR;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   modport master (
      output PSEL, PADDR, PENABLE, PWRITE, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PADDR, PENABLE, PWRITE, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb3_fifo_slave.sv
// APB3 mailbox FIFO completer with programmable wait states, sticky ovf/unf flags and PSLVERR.
// Define APB3_FIFO_THRESH_IRQ_EN to map the THRESH register and add the threshold interrupt.
module apb3_fifo_slave #(
   parameter int DEPTH       = 16,
   parameter int WAIT_STATES = 0,
   parameter int DATA_WIDTH  = 32
) (
   input  logic                PCLK,
   input  logic                PRESET,
   apb3_fifo_slave_if.slave    apb,
   output logic                IRQ
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   typedef enum logic [1:0] {IDLE, SETUP, WAIT, DONE} state_t;

   state_t                state;
   logic [3:0]            wcnt, wcnt_nxt;
   logic                  done;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         wptr, rptr;
   logic [CW-1:0]         count;
   logic                  ovf, unf, empty, full, thr_irq, err;
   logic [2:0]            addr;
   logic                  wr;
   logic [8:0]            count_ext;
   logic [7:0]            cnt8;
   logic [31:0]           status, rdata;
   logic                  unused_paddr;

   assign unused_paddr = ^apb.PADDR[1:0];

   // Phase is decoded from the live bus; only the wait counter is state.
   always_comb begin
      state    = IDLE;
      wcnt_nxt = '0;
      if (apb.PSEL && !apb.PENABLE) begin
         state = SETUP;
      end else if (apb.PSEL && apb.PENABLE) begin
         if (wcnt != 4'(WAIT_STATES)) begin
            state    = WAIT;
            wcnt_nxt = wcnt + 4'd1;
         end else begin
            state    = DONE;
            wcnt_nxt = wcnt;
         end
      end
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) wcnt <= '0;
      else        wcnt <= wcnt_nxt;
   end

   assign done       = (state == DONE) && !PRESET;
   assign apb.PREADY = done;

   assign addr  = apb.PADDR[4:2];
   assign wr    = apb.PWRITE;
   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));

   assign count_ext = 9'(count);
   assign cnt8      = count_ext[8] ? 8'hFF : count_ext[7:0];

`ifdef APB3_FIFO_THRESH_IRQ_EN
   logic [7:0] thresh;
   assign thr_irq = (count_ext >= {1'b0, thresh}) && (thresh != 8'd0);
`else
   assign thr_irq = 1'b0;
`endif

   assign status = {16'b0, cnt8, 3'b0, thr_irq, unf, ovf, full, empty};
   assign IRQ    = ovf | unf | thr_irq;

   always_comb begin
      err   = 1'b0;
      rdata = '0;
      case (addr)
         3'd0: begin
            if (wr)         err   = full;
            else if (empty) err   = 1'b1;
            else            rdata = mem[rptr];
         end
         3'd1: begin
            if (wr) err   = 1'b1;
            else    rdata = status;
         end
         3'd2: ;
`ifdef APB3_FIFO_THRESH_IRQ_EN
         3'd3: if (!wr) rdata = {24'b0, thresh};
`endif
         default: err = 1'b1;
      endcase
   end

   assign apb.PRDATA  = (done && !wr) ? rdata : '0;
   assign apb.PSLVERR = done && err;

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         ovf   <= 1'b0;
         unf   <= 1'b0;
`ifdef APB3_FIFO_THRESH_IRQ_EN
         thresh <= 8'(DEPTH / 2);
`endif
      end else if (done) begin
         case (addr)
            3'd0: begin
               if (wr) begin
                  if (full) ovf <= 1'b1;
                  else begin
                     wptr  <= wptr + PW'(1);
                     count <= count + CW'(1);
                  end
               end else begin
                  if (empty) unf <= 1'b1;
                  else begin
                     rptr  <= rptr + PW'(1);
                     count <= count - CW'(1);
                  end
               end
            end
            3'd2: begin
               // Flush leaves storage untouched; both bits may act in one write.
               if (wr && apb.PWDATA[0]) begin
                  wptr  <= '0;
                  rptr  <= '0;
                  count <= '0;
               end
               if (wr && apb.PWDATA[1]) begin
                  ovf <= 1'b0;
                  unf <= 1'b0;
               end
            end
`ifdef APB3_FIFO_THRESH_IRQ_EN
            3'd3: if (wr) thresh <= apb.PWDATA[7:0];
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge PCLK) begin
      if (done && addr == 3'd0 && wr && !full) mem[wptr] <= apb.PWDATA;
   end
endmodule
